// File: rtl/bps_pkg.sv
// ============================================================================
// bps_pkg
// Shared BP-S opcode constants, opcode width and controller state encoding.
// Revision: 1.0
// ============================================================================
`default_nettype none

package bps_pkg;

  localparam int OPCODE_W = 3;

  localparam logic [OPCODE_W-1:0] OP_IDLE       = 3'd0;
  localparam logic [OPCODE_W-1:0] OP_LOAD       = 3'd1;
  localparam logic [OPCODE_W-1:0] OP_DOWN       = 3'd2;
  localparam logic [OPCODE_W-1:0] OP_UP         = 3'd3;
  localparam logic [OPCODE_W-1:0] OP_STORE_DOWN = 3'd4;
  localparam logic [OPCODE_W-1:0] OP_STORE_UP   = 3'd5;

  localparam int STATE_W = 2;

  localparam logic [STATE_W-1:0] ST_IDLE  = 2'd0;
  localparam logic [STATE_W-1:0] ST_ISSUE = 2'd1;
  localparam logic [STATE_W-1:0] ST_DRAIN = 2'd2;

  function automatic logic op_is_legal(input logic [OPCODE_W-1:0] op);
    return (op >= OP_LOAD) && (op <= OP_STORE_UP);
  endfunction

endpackage

`default_nettype wire

// File: rtl/bps_node_counter.sv
// ============================================================================
// bps_node_counter
// Loadable up/down node counter with end-of-chain detect; never wraps.
// Revision: 1.0
// ============================================================================
`default_nettype none

module bps_node_counter #(
  parameter int NUM_NODES = 16,
  parameter int NODE_W    = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_load,
  input  logic              i_down,
  input  logic              i_step,
  output logic [NODE_W-1:0] o_node,
  output logic              o_last
);

  localparam logic [NODE_W-1:0] C_TOP = NODE_W'(NUM_NODES - 1);

  logic              r_down;
  logic [NODE_W-1:0] r_node;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_down <= 1'b0;
      r_node <= '0;
    end else if (i_load) begin
      r_down <= i_down;
      r_node <= i_down ? C_TOP : '0;
    end else if (i_step && !o_last) begin
      r_node <= r_down ? (r_node - 1'b1) : (r_node + 1'b1);
    end
  end

  assign o_node = r_node;
  assign o_last = r_down ? (r_node == '0) : (r_node == C_TOP);

endmodule

`default_nettype wire

// File: rtl/bps_slave_ctrl.sv
// ============================================================================
// bps_slave_ctrl
// BP-S responder: expands opcodes into per-node datapath steps, stalls master.
// Optional perf counters (op_cycles/op_count) under BPS_SLAVE_PERF_EN.
// Revision: 1.0
// ============================================================================
`default_nettype none

module bps_slave_ctrl
  import bps_pkg::*;
#(
  parameter int NUM_NODES = 16,
  parameter int NODE_W    = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [OPCODE_W-1:0] bps_opcode,
  output logic                bps_stall,
  output logic                dp_valid,
  output logic [OPCODE_W-1:0] dp_op,
  output logic [NODE_W-1:0]   dp_node,
  output logic                dp_last,
  input  logic                dp_ready,
  input  logic                dp_idle,
  output logic                op_err
`ifdef BPS_SLAVE_PERF_EN
  ,
  output logic [15:0]         op_cycles,
  output logic [15:0]         op_count
`endif
);

  logic [STATE_W-1:0]  r_state;
  logic [STATE_W-1:0]  w_state_nxt;
  logic                r_stall;
  logic [OPCODE_W-1:0] r_op;
  logic                r_err;
  logic                w_accept;
  logic                w_valid;
  logic                w_step;
  logic                w_last;
  logic                w_err_set;

  assign w_accept  = (r_state == ST_IDLE) && op_is_legal(bps_opcode);
  assign w_err_set = (r_state == ST_IDLE) ? (bps_opcode > OP_STORE_UP)
                                          : (bps_opcode != OP_IDLE);

  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:  if (w_accept)           w_state_nxt = ST_ISSUE;
      ST_ISSUE: if (dp_ready && w_last) w_state_nxt = ST_DRAIN;
      ST_DRAIN: if (dp_idle)            w_state_nxt = ST_IDLE;
      default:                          w_state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    w_valid = (r_state == ST_ISSUE);
    w_step  = w_valid && dp_ready;
  end

  // Stall is its own flop so it rises on the accepting edge, not a cycle late.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_stall <= 1'b0;
      r_op    <= OP_IDLE;
      r_err   <= 1'b0;
    end else begin
      if (w_accept) begin
        r_stall <= 1'b1;
        r_op    <= bps_opcode;
      end else if ((r_state == ST_DRAIN) && dp_idle) begin
        r_stall <= 1'b0;
      end
      if (w_err_set) r_err <= 1'b1;
    end
  end

  bps_node_counter #(
    .NUM_NODES (NUM_NODES),
    .NODE_W    (NODE_W)
  ) u_node_counter (
    .clk    (clk),
    .rst    (rst),
    .i_load (w_accept),
    .i_down (bps_opcode == OP_UP),
    .i_step (w_step),
    .o_node (dp_node),
    .o_last (w_last)
  );

  assign bps_stall = r_stall;
  assign dp_valid  = w_valid;
  assign dp_op     = r_op;
  assign dp_last   = w_valid && w_last;
  assign op_err    = r_err;

`ifdef BPS_SLAVE_PERF_EN
  logic [15:0] r_run;
  logic [15:0] r_cycles;
  logic [15:0] r_count;
  logic [15:0] w_run_inc;

  assign w_run_inc = (r_run == 16'hFFFF) ? r_run : (r_run + 16'd1);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_run    <= '0;
      r_cycles <= '0;
      r_count  <= '0;
    end else begin
      if (w_accept)                r_run <= '0;
      else if (r_state != ST_IDLE) r_run <= w_run_inc;
      if ((r_state == ST_DRAIN) && dp_idle) begin
        r_cycles <= w_run_inc;
        r_count  <= r_count + 16'd1;
      end
    end
  end

  assign op_cycles = r_cycles;
  assign op_count  = r_count;
`endif

endmodule

`default_nettype wire

// File: tb/tb_bps_slave_ctrl.sv
// ============================================================================
// tb_bps_slave_ctrl
// Scoreboard bench: stimulus pushes expected steps/stall lengths, monitor pops.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_bps_slave_ctrl;
  import bps_pkg::*;

  localparam int N  = 16;
  localparam int NW = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [2:0]    bps_opcode = 3'd0;
  logic          dp_ready = 1'b0;
  logic          dp_idle = 1'b0;
  logic          bps_stall;
  logic          dp_valid;
  logic [2:0]    dp_op;
  logic [NW-1:0] dp_node;
  logic          dp_last;
  logic          op_err;
`ifdef BPS_SLAVE_PERF_EN
  logic [15:0]   op_cycles;
  logic [15:0]   op_count;
`endif

  bps_slave_ctrl #(.NUM_NODES(N), .NODE_W(NW)) dut (
    .clk        (clk),
    .rst        (rst),
    .bps_opcode (bps_opcode),
    .bps_stall  (bps_stall),
    .dp_valid   (dp_valid),
    .dp_op      (dp_op),
    .dp_node    (dp_node),
    .dp_last    (dp_last),
    .dp_ready   (dp_ready),
    .dp_idle    (dp_idle),
    .op_err     (op_err)
`ifdef BPS_SLAVE_PERF_EN
    ,
    .op_cycles  (op_cycles),
    .op_count   (op_count)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]    op;
    logic [NW-1:0] node;
    logic          last;
  } step_t;

  step_t exp_q[$];
  int    exp_len_q[$];
  int    n_cmp = 0;
  int    n_bad = 0;
  logic  exp_err = 1'b0;
  bit    aborted = 1'b0;
  int    stall_cnt = 0;
  int    exp_len;
  int    n_done = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: compares every presented step and every completed stall window.
  always @(negedge clk) begin
    if (rst) begin
      n_done    = 0;
    end else begin
      chk("op_err", {31'd0, op_err}, {31'd0, exp_err});
      if (dp_valid) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_step: got node %0d op %0d, none expected", dp_node, dp_op);
        end else begin
          chk("dp_op",   {29'd0, dp_op},   {29'd0, exp_q[0].op});
          chk("dp_node", {28'd0, dp_node}, {28'd0, exp_q[0].node});
          chk("dp_last", {31'd0, dp_last}, {31'd0, exp_q[0].last});
          if (dp_ready) void'(exp_q.pop_front());
        end
      end
      if (bps_stall) begin
        stall_cnt++;
      end else if (stall_cnt > 0) begin
        if (exp_len_q.size() > 0) begin
          exp_len = exp_len_q.pop_front();
          n_done++;
          chk("stall_len", stall_cnt, exp_len);
`ifdef BPS_SLAVE_PERF_EN
          chk("op_cycles", {16'd0, op_cycles}, exp_len);
          chk("op_count",  {16'd0, op_count},  n_done & 32'hFFFF);
`endif
        end else if (aborted) begin
          aborted = 1'b0;
        end else begin
          chk("unexpected_stall_len", stall_cnt, 0);
        end
        stall_cnt = 0;
      end
    end
  end

  // Expected behaviour derived from the ready/idle patterns this task will drive.
  task automatic run_op(input logic [2:0] op, input int rmode, input int drain_wait, input int inj);
    bit rdy[512];
    int hs, k, last_hs, len;
    step_t s;
    for (int i = 0; i < 512; i++) begin
      if (rmode == 0)      rdy[i] = 1'b1;
      else if (rmode == 1) rdy[i] = (i % 2 == 1);
      else                 rdy[i] = (i >= 400) ? 1'b1 : 1'($urandom_range(0, 1));
    end
    hs = 0;
    k  = 0;
    while (hs < N) begin
      if (rdy[k]) hs++;
      k++;
    end
    last_hs = k - 1;
    len = last_hs + 1 + drain_wait + 1;
    for (int i = 0; i < N; i++) begin
      s.op   = op;
      s.node = NW'((op == OP_UP) ? (N - 1 - i) : i);
      s.last = (i == N - 1);
      exp_q.push_back(s);
    end
    exp_len_q.push_back(len);
    bps_opcode = op;
    @(posedge clk) #1;
    for (int c = 0; c < len; c++) begin
      dp_ready   = rdy[c];
      dp_idle    = (c >= last_hs + 1 + drain_wait);
      bps_opcode = (c == inj) ? OP_DOWN : OP_IDLE;
      if (inj >= 0 && c == inj + 1) exp_err = 1'b1;
      @(posedge clk) #1;
    end
    bps_opcode = OP_IDLE;
    dp_ready   = 1'($urandom_range(0, 1));
    dp_idle    = 1'($urandom_range(0, 1));
  endtask

  task automatic err_idle(input logic [2:0] op);
    bps_opcode = op;
    @(posedge clk) #1;
    bps_opcode = OP_IDLE;
    exp_err    = 1'b1;
    @(negedge clk);
    chk("stall_after_illegal", {31'd0, bps_stall}, 32'd0);
    @(posedge clk) #1;
  endtask

  task automatic abort_op();
    step_t s;
    for (int i = 0; i < 7; i++) begin
      s.op = OP_LOAD; s.node = NW'(i); s.last = 1'b0;
      exp_q.push_back(s);
    end
    aborted    = 1'b1;
    dp_ready   = 1'b1;
    dp_idle    = 1'b1;
    bps_opcode = OP_LOAD;
    @(posedge clk) #1;
    bps_opcode = OP_IDLE;
    repeat (7) @(posedge clk) #1;
    rst      = 1'b1;
    dp_ready = 1'b0;
    @(negedge clk);
    chk("abort_node_before", {28'd0, dp_node}, 32'd7);
    @(posedge clk) #1;
    rst     = 1'b0;
    exp_err = 1'b0;
    @(negedge clk);
    chk("abort_stall", {31'd0, bps_stall}, 32'd0);
    chk("abort_valid", {31'd0, dp_valid},  32'd0);
    chk("abort_node",  {28'd0, dp_node},   32'd0);
    @(posedge clk) #1;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst        = 1'b1;
    bps_opcode = OP_LOAD;
    dp_ready   = 1'b1;
    dp_idle    = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("rst_stall", {31'd0, bps_stall}, 32'd0);
      chk("rst_valid", {31'd0, dp_valid},  32'd0);
      chk("rst_op",    {29'd0, dp_op},     32'd0);
      chk("rst_node",  {28'd0, dp_node},   32'd0);
      chk("rst_last",  {31'd0, dp_last},   32'd0);
      chk("rst_err",   {31'd0, op_err},    32'd0);
    end
    @(posedge clk) #1;
    rst        = 1'b0;
    bps_opcode = OP_IDLE;
    @(negedge clk);
    chk("post_rst_stall", {31'd0, bps_stall}, 32'd0);
    @(posedge clk) #1;

    run_op(OP_LOAD, 0, 0, -1);
    run_op(OP_UP, 1, 0, -1);
    run_op(OP_STORE_DOWN, 0, 5, -1);
    err_idle(3'd6);
    run_op(OP_DOWN, 0, 0, 4);
    err_idle(3'd7);
    for (int i = 0; i < 6; i++)
      run_op(3'($urandom_range(1, 5)), 2, int'($urandom_range(0, 3)), -1);
    abort_op();
    run_op(OP_STORE_UP, 2, 1, -1);
    run_op(OP_UP, 0, 0, -1);

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("steps_left",  exp_q.size(),     32'd0);
    chk("stalls_left", exp_len_q.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/bps_slave_ctrl.md
# bps_slave_ctrl

Responder-side controller for the sequential belief-propagation (BP-S) engine. It accepts the 3-bit `bps_opcode` stream issued by the BP-S master and asserts `bps_stall` while an operation is running. Each accepted operation is expanded into a per-node sequence of datapath step commands over a valid/ready handshake. It then waits for the datapath to drain before releasing the stall.

## Interface
Parameters:
- `NUM_NODES`, 16: nodes per chain; 1 ≤ NUM_NODES ≤ 2^NODE_W.
- `NODE_W`, 4: width of the node index.

Ports:
- `clk`  in  1  clock.
- `rst`  in  1  reset, synchronous, active-high.
- `bps_opcode`  in  3  encoding: 0 IDLE, 1 LOAD, 2 DOWN, 3 UP, 4 STORE_DOWN, 5 STORE_UP; 6–7 illegal.
- `bps_stall`  out  1  busy; registered.
- `dp_valid`  out  1  step command valid.
- `dp_op`  out  3  opcode of the current operation.
- `dp_node`  out  NODE_W  node index of the current step.
- `dp_last`  out  1  current step is the final step of the operation.
- `dp_ready`  in  1  datapath accepts the step.
- `dp_idle`  in  1  datapath has no steps in flight.
- `op_err`  out  1  sticky protocol-error flag.

## Operation
- States: IDLE, ISSUE, DRAIN.
- **IDLE**
  - Opcode 1–5: latch it into `dp_op`, then go to ISSUE.
  - Start node is NUM_NODES-1 for UP and 0 for all other opcodes.
  - Opcode 0: stay in IDLE.
  - Opcode 6–7: not accepted. Set `op_err`, stay in IDLE, `bps_stall` stays 0.
- **ISSUE**
  - `dp_valid`=1.
  - On `dp_valid & dp_ready`:
    - If `dp_last`: go to DRAIN.
    - Otherwise advance `dp_node`: +1, or -1 for UP.
  - `dp_last` = (`dp_node` == NUM_NODES-1), or (`dp_node` == 0) for UP.
  - Node counter never wraps.
- **DRAIN**
  - `dp_valid`=0.
  - When `dp_idle`=1: go to IDLE and clear `bps_stall`.
- A nonzero opcode seen while in ISSUE or DRAIN is ignored and sets `op_err`.
- `op_err` clears only on reset.
- `dp_op` and `dp_node` hold their values while `dp_valid & !dp_ready`.

## Timing
- Reset values: `bps_stall`=0, `dp_valid`=0, `dp_op`=0, `dp_node`=0, `dp_last`=0, `op_err`=0, state IDLE.
- `rst` during ISSUE or DRAIN aborts immediately. No further steps are issued.
- `bps_stall` rises on the same edge that samples an accepted opcode in IDLE. The master therefore sees stall=1 in the first cycle after presenting the opcode.
- `dp_valid`, `dp_op`, `dp_node` and `dp_last` are valid from the cycle after opcode acceptance.
- Minimum stall duration is NUM_NODES+1 cycles: NUM_NODES issue cycles with `dp_ready`=1, plus one DRAIN cycle with `dp_idle`=1.
- `bps_stall` falls on the edge at which DRAIN samples `dp_idle`=1.
- A new opcode is accepted in the first cycle `bps_stall`=0, so back-to-back operations are possible.
- NUM_NODES=1: the first step is also the last; `dp_last`=1 immediately.

## Configuration
- `BPS_SLAVE_PERF_EN`
  - **Defined:** adds outputs `op_cycles` (16 bits) and `op_count` (16 bits).
    - `op_cycles` = number of cycles `bps_stall` was high for the most recently completed operation; saturates at 0xFFFF; updated on the DRAIN→IDLE edge.
    - `op_count` increments per completed operation and wraps.
    - Both reset to 0.
  - **Undefined:** the ports and counters are absent. All other behaviour is identical.

## Structure
- Shared package `bps_pkg` holds:
  - opcode constants OP_IDLE … OP_STORE_UP;
  - the controller state encoding;
  - the opcode width, which the master uses as well.
- One sub-module, `bps_node_counter`: loadable up/down counter with a `last` detect for the configured direction.

## Test plan
- **Reset:** hold `rst`, drive opcode=1. All outputs stay 0 and the opcode is not accepted.
- **LOAD:** opcode=1 for one cycle, NUM_NODES=16, `dp_ready`=1, `dp_idle`=1.
  - `dp_node` steps 0..15, with `dp_last` only at 15.
  - `bps_stall` is high for exactly 17 cycles.
- **UP with backpressure:** opcode=3, `dp_ready` toggling every cycle.
  - `dp_node` runs 15..0 and holds value while not ready.
  - Stall remains high until `dp_idle` is seen in DRAIN.
- **Drain hold:** `dp_idle`=0 for 5 cycles after the last step. `bps_stall` stays high 5 extra cycles and `dp_valid`=0 throughout.
- **Errors:**
  - opcode=6 in IDLE: `op_err`=1 and no stall.
  - opcode=2 during ISSUE: ignored, `op_err`=1, and the current sequence completes unchanged.
- **Abort:** assert `rst` mid-ISSUE at node 7. On the next cycle `bps_stall`=0, `dp_valid`=0, `dp_node`=0.
